// File: rtl/rx_cdr_pkg.sv
// Shared Rx clock-recovery definitions: loop FSM states, width helpers and the
// saturation function used by the phase detector and the loop filter.
package rx_cdr_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, TRACK} cdr_state_t;

  function automatic int err_width(input int adc_bit);
    return adc_bit + 1;
  endfunction

  function automatic int acc_width(input int adc_bit, input int dec_log2);
    return adc_bit + 1 + dec_log2;
  endfunction

  // Clamp v into the signed range of a w-bit two's complement value.
  function automatic int saturate(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mmpd_err.sv
// Mueller-Muller error e[n] = d[n-1]*x[n] - d[n]*x[n-1], built from conditional
// negates; purely combinational.
module mmpd_err #(
  parameter int ADC_BIT = 8
) (
  input  logic signed [ADC_BIT-1:0] x,
  input  logic signed [ADC_BIT-1:0] x_prev,
  output logic signed [ADC_BIT:0]   err
);

  localparam int W = ADC_BIT + 2;

  logic signed [W-1:0] xs;
  logic signed [W-1:0] ps;
  logic signed [W-1:0] t1;
  logic signed [W-1:0] t2;
  logic signed [W-1:0] diff;

  // A set sign bit means the decision is -1, so that term is negated.
  always_comb begin
    xs   = W'(x);
    ps   = W'(x_prev);
    t1   = x_prev[ADC_BIT-1] ? -xs : xs;
    t2   = x[ADC_BIT-1] ? -ps : ps;
    diff = t1 - t2;
    err  = diff[ADC_BIT:0];
  end

endmodule

// File: rtl/mm_phase_detector.sv
// MM timing-error detector with block-average decimation and IDLE/SETTLE/TRACK start-up.
// MMPD_BANG_BANG_EN: when defined, each block outputs only the sign of its error sum.
module mm_phase_detector
  import rx_cdr_pkg::*;
#(
  parameter int ADC_BIT    = 8,
  parameter int DEC_LOG2   = 2,
  parameter int SETTLE_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic [ADC_BIT-1:0] in,
  output logic [ADC_BIT-1:0] out,
  output logic               out_valid,
  output logic               filter_en
);

  localparam int ERR_W    = err_width(ADC_BIT);
  localparam int ACC_W    = acc_width(ADC_BIT, DEC_LOG2);
  localparam int SCNT_W   = $clog2(SETTLE_CYC + 1);
  localparam int BCNT_W   = DEC_LOG2 + 1;
  localparam int BLK_LAST = (1 << DEC_LOG2) - 1;

  cdr_state_t               state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic [SCNT_W-1:0]        settle_cnt;
  logic [BCNT_W-1:0]        blk_cnt;
  logic [ADC_BIT-1:0]       x_prev;
  logic                     hist_vld;
  logic signed [ERR_W-1:0]  err;
  logic [ADC_BIT-1:0]       result;

  mmpd_err #(.ADC_BIT(ADC_BIT)) u_err (
    .x      (in),
    .x_prev (x_prev),
    .err    (err)
  );

  assign sum = acc + ACC_W'(err);

`ifdef MMPD_BANG_BANG_EN
  always_comb begin
    result = '0;
    if (sum > 0)
      result = ADC_BIT'(1);
    else if (sum < 0)
      result = '1;
  end
`else
  logic signed [ACC_W-1:0] shifted;
  assign shifted = sum >>> DEC_LOG2;
  assign result  = ADC_BIT'(saturate(int'(shifted), ADC_BIT));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out        <= '0;
      out_valid  <= 1'b0;
      filter_en  <= 1'b0;
      acc        <= '0;
      settle_cnt <= '0;
      blk_cnt    <= '0;
      x_prev     <= '0;
      hist_vld   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (!en) begin
        // Any partial block is dropped; out holds its last value.
        state      <= IDLE;
        filter_en  <= 1'b0;
        acc        <= '0;
        settle_cnt <= '0;
        blk_cnt    <= '0;
        hist_vld   <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SETTLE;
          SETTLE: begin
            if (in_valid) begin
              x_prev   <= in;
              hist_vld <= 1'b1;
              if (settle_cnt == SCNT_W'(SETTLE_CYC - 1)) begin
                state      <= TRACK;
                filter_en  <= 1'b1;
                settle_cnt <= '0;
              end else begin
                settle_cnt <= settle_cnt + 1'b1;
              end
            end
          end
          TRACK: begin
            if (in_valid && hist_vld) begin
              x_prev <= in;
              if (blk_cnt == BCNT_W'(BLK_LAST)) begin
                out       <= result;
                out_valid <= 1'b1;
                acc       <= '0;
                blk_cnt   <= '0;
              end else begin
                acc     <= sum;
                blk_cnt <= blk_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mm_phase_detector.md
# mm_phase_detector

Digital Mueller-Muller timing-error detector for the Rx clock-recovery loop. It consumes signed ADC samples, forms the MM timing error from sign decisions and sample history, decimates by block-averaging, and drives the signed error input and `filter_en` of the Rx PLL digital loop filter. It sequences loop start-up: idle, then a settling window, then tracking.

## Interface
- `ADC_BIT`, 8: sample and error-output width, two's complement.
- `DEC_LOG2`, 2: log2 of decimation; one output per 2^DEC_LOG2 error samples; 0 is legal.
- `SETTLE_CYC`, 64: number of accepted samples spent in SETTLE before tracking; must be at least 1.
- `clk` in 1: single clock; all state on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: loop enable; low forces IDLE.
- `in_valid` in 1: `in` carries a sample this cycle.
- `in` in ADC_BIT: signed ADC sample x[n].
- `out` out ADC_BIT: signed averaged MM error, to loop-filter `in`.
- `out_valid` out 1: one-cycle strobe when `out` updates.
- `filter_en` out 1: loop-filter enable; high only in TRACK.

## Operation
- Decision: d[n] = +1 if x[n] >= 0, else -1 (sign bit of `in`).
- Error: e[n] = d[n-1]*x[n] - d[n]*x[n-1].
  - Implement e[n] as a conditional negate/add, not a multiplier.
  - Width is ADC_BIT+1; range is [-2^(ADC_BIT-1), +2^(ADC_BIT-1)].
- Accumulator width is ADC_BIT+1+DEC_LOG2, so it never overflows within a block.
- Block result: (acc + e) arithmetic-shifted right by DEC_LOG2 (floor), then saturated to [-2^(ADC_BIT-1), 2^(ADC_BIT-1)-1].
- FSM states:
  - IDLE: history invalid, counters cleared, `filter_en`=0. When `en`=1, go to SETTLE next cycle.
  - SETTLE: every accepted sample loads history (x[n-1], d[n-1]). Sample counter counts to SETTLE_CYC; on the SETTLE_CYC-th accepted sample go to TRACK. No accumulation and no `out_valid` in this state.
  - TRACK: each accepted sample computes e[n], adds it to acc, and updates history. On the 2^DEC_LOG2-th sample of a block, register the block result into `out`, pulse `out_valid`, clear acc and the block counter.
- `en`=0 in any state: go to IDLE next edge. This clears `filter_en`, acc, counters and the history-valid flag, and discards any partial block. `out` keeps its last value.
- Samples with `in_valid`=0 are ignored entirely: no history update and no count.
- Reset: state=IDLE, `out`=0, `out_valid`=0, `filter_en`=0, acc=0, counters=0, history=0 and invalid.

## Timing
- `out`/`out_valid` latency: one cycle after the edge that accepts the last sample of a block. `out_valid` is high for exactly one cycle.
- `filter_en` rises on the same edge as the SETTLE→TRACK transition. It falls on the first edge with `en`=0.
- Back-to-back `in_valid` is supported every cycle. With DEC_LOG2=0, `out_valid` can be high on consecutive cycles.
- `en` deasserted on the same cycle as a block-completing sample: IDLE wins; no `out_valid`.
- `rst` mid-block: immediate clear; no partial output.

## Configuration
- `MMPD_BANG_BANG_EN`:
  - Defined: the block result is replaced by its sign. `out` = +1 if the sum > 0, -1 if < 0, 0 if = 0. The accumulator is unchanged.
  - Undefined: the saturated average described above.

## Structure
- Shared package `rx_cdr_pkg`:
  - FSM state enum {IDLE, SETTLE, TRACK}.
  - Width helper constants: error width ADC_BIT+1, accumulator width.
  - The saturate function, shared with the loop filter.
- One sub-module, `mmpd_err`: combinational e[n] from `in`, x[n-1] and d[n-1]. Everything else lives in the top.

## Test plan
- Reset/IDLE: `rst` pulse, `en`=0, 10 valid samples → `out`=0, `out_valid`=0, `filter_en`=0 throughout.
- Settle count: SETTLE_CYC=4, `en`=1, valid samples with gaps → `filter_en` rises on the edge accepting the 4th valid sample; no `out_valid` before then.
- Ramp, DEC_LOG2=2: settle ends on x=0, then TRACK samples 10, 20, 30, 40 → errors 10 each; `out`=10 with one `out_valid` pulse one cycle after the 4th sample.
- Zero error: constant x=+20, or alternating +40/-40 → `out`=0 every block.
- Saturation, DEC_LOG2=0: history x=-128, then sample 0 → e=+128 → `out`=127. With `MMPD_BANG_BANG_EN` defined → `out`=1.
- Abort: `en` dropped after 3 of 4 block samples, re-enabled → no `out_valid`; a full SETTLE is repeated; the first block after re-entry uses fresh history.
